spi_slave_byte: RTL

- Byte-level SPI slave front end for the host command port (ssclk/scsn/smosi/smiso) of the TMC controller FPGA.
- Synchronises the asynchronous host pins into the clk domain and deserialises MOSI into bytes.
- Serialises a response byte stream onto MISO and marks frame and byte boundaries for the downstream command decoder.
- SPI mode 3, MSB first: ssclk idles high, host changes MOSI on the falling edge, both sides sample on the rising edge.

---
 rtl/spi_slave_byte.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave_byte.sv
// Byte-level SPI mode-3 slave: synchronises the host pins into clk, deserialises MOSI,
// serialises response bytes onto MISO and flags frame/byte boundaries.
module spi_slave_byte #(
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ssclk,
    input  logic             scsn,
    input  logic             smosi,
    output logic             smiso,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic [IDX_W-1:0] byte_idx,
    input  logic [7:0]       tx_data,
    output logic             tx_load,
    output logic             frame_start,
    output logic             frame_end,
    output logic             rx_partial
);

    localparam int unsigned BIT_W = 3;
    localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(7);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t state, state_nxt;

    logic sclk_s1, sclk_s2, sclk_h;
    logic csn_s1, csn_s2, csn_h;
    logic mosi_s1, mosi_s2;

    logic sclk_rise, csn_fall, csn_rise;

    logic [7:0]       rx_shift, rx_shift_nxt;
    logic [7:0]       tx_shift, tx_shift_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [7:0]       rx_data_nxt;
    logic [IDX_W-1:0] byte_idx_nxt;
    logic             idx_inc, idx_inc_nxt;
    logic             rx_valid_nxt, tx_load_nxt, frame_start_nxt, frame_end_nxt, rx_partial_nxt;

    // Chip-select syncs reset low so a select held through reset never looks like a fresh fall
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_s1 <= 1'b1;
            sclk_s2 <= 1'b1;
            sclk_h  <= 1'b1;
            csn_s1  <= 1'b0;
            csn_s2  <= 1'b0;
            csn_h   <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= ssclk;
            sclk_s2 <= sclk_s1;
            sclk_h  <= sclk_s2;
            csn_s1  <= scsn;
            csn_s2  <= csn_s1;
            csn_h   <= csn_s2;
            mosi_s1 <= smosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_h;
    assign csn_fall  = ~csn_s2 & csn_h;
    assign csn_rise  = csn_s2 & ~csn_h;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            rx_shift    <= '0;
            tx_shift    <= '0;
            bit_cnt     <= '0;
            rx_data     <= '0;
            byte_idx    <= '0;
            idx_inc     <= 1'b0;
            rx_valid    <= 1'b0;
            tx_load     <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            rx_partial  <= 1'b0;
        end else begin
            state       <= state_nxt;
            rx_shift    <= rx_shift_nxt;
            tx_shift    <= tx_shift_nxt;
            bit_cnt     <= bit_cnt_nxt;
            rx_data     <= rx_data_nxt;
            byte_idx    <= byte_idx_nxt;
            idx_inc     <= idx_inc_nxt;
            rx_valid    <= rx_valid_nxt;
            tx_load     <= tx_load_nxt;
            frame_start <= frame_start_nxt;
            frame_end   <= frame_end_nxt;
            rx_partial  <= rx_partial_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        rx_shift_nxt    = rx_shift;
        tx_shift_nxt    = tx_shift;
        bit_cnt_nxt     = bit_cnt;
        rx_data_nxt     = rx_data;
        byte_idx_nxt    = byte_idx;
        idx_inc_nxt     = 1'b0;
        rx_valid_nxt    = 1'b0;
        tx_load_nxt     = 1'b0;
        frame_start_nxt = 1'b0;
        frame_end_nxt   = 1'b0;
        rx_partial_nxt  = 1'b0;

        // Index advances one cycle after rx_valid so the pulse carries the completed byte's index
        if (idx_inc && byte_idx != IDX_MAX) begin
            byte_idx_nxt = byte_idx + IDX_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (csn_fall) begin
                    state_nxt       = S_ACTIVE;
                    frame_start_nxt = 1'b1;
                    tx_load_nxt     = 1'b1;
                    tx_shift_nxt    = tx_data;
                    bit_cnt_nxt     = '0;
                    byte_idx_nxt    = '0;
                end
            end
            S_ACTIVE: begin
            end
            default: state_nxt = S_IDLE;
        endcase

        // A rise coinciding with the select fall is taken as the first bit of byte 0
        if ((state == S_ACTIVE || csn_fall) && sclk_rise) begin
            rx_shift_nxt = {rx_shift[6:0], mosi_s2};
            if (bit_cnt_nxt == LAST_BIT) begin
                rx_data_nxt  = {rx_shift[6:0], mosi_s2};
                rx_valid_nxt = 1'b1;
                tx_load_nxt  = 1'b1;
                tx_shift_nxt = tx_data;
                bit_cnt_nxt  = '0;
                idx_inc_nxt  = 1'b1;
            end else begin
                tx_shift_nxt = {tx_shift_nxt[6:0], 1'b0};
                bit_cnt_nxt  = bit_cnt_nxt + BIT_W'(1);
            end
        end

        if (state == S_ACTIVE && csn_rise) begin
            frame_end_nxt  = 1'b1;
            rx_partial_nxt = (bit_cnt_nxt != '0);
            bit_cnt_nxt    = '0;
            state_nxt      = S_IDLE;
        end
    end

    assign smiso = tx_shift[7];

endmodule
